ram_refresh_seq: RTL
====================

Name: ram_refresh_seq

Overview:
- Downstream consumer of the refresh timer's RefReq/RefUrg outputs.
- Sequences DRAM strobes for CPU RAM accesses and CAS-before-RAS refresh cycles, arbitrating between them.
- Normal refreshes are deferred until the bus is idle; urgent refreshes preempt new accesses.
- Counts refresh intervals that end without a completed refresh, for debug and verification.

Parameters:
- TRP, 2: precharge cycles (nRAS/nCAS high) after any cycle, 1..7.
- TRAS, 3: nRAS-low cycles during a refresh, 1..7.

Ports:
- CLK  in  1  FSB clock; single clock domain.
- nRES  in  1  reset, synchronous, active-low.
- RefReq  in  1  refresh window open; low for one E period at each interval start.
- RefUrg  in  1  refresh overdue; preempt new accesses.
- BACT  in  1  bus cycle active.
- RAMCS  in  1  current bus cycle addresses RAM.
- RW  in  1  1 = read, 0 = write.
- nRAS  out  1  DRAM row strobe.
- nCAS  out  1  DRAM column strobe.
- RASMux  out  1  0 = row address, 1 = column address.
- nOE  out  1  DRAM output enable, low on reads only.
- RAMReady  out  1  access data phase ready.
- RefBusy  out  1  refresh cycle in progress, including its precharge.
- RefMiss  out  4  saturating count of missed refresh intervals.

Behaviour:
- All outputs are registered and take their state-entry values on the edge that enters the state.
- Reset: on any CLK edge with nRES=0, regardless of the current state:
  - state=IDLE; nRAS=nCAS=nOE=1; RASMux=0; RAMReady=0; RefBusy=0.
  - RefDone=0; RefMiss=0; counters=0.
  - Reset mid-cycle releases all strobes on that edge.
- Refresh bookkeeping:
  - RefDone is cleared while RefReq=0.
  - RefDone is set on entry to PRE from REF_RAS.
  - Pending = RefReq && !RefDone.
  - Registered RefReq falls while Pending=1 -> RefMiss+1, saturating at 15.
  - If RefReq falls on the same edge RefDone is set, no miss is counted.
- States and transitions:
  - IDLE, evaluated in this priority order:
    1. Pending && (RefUrg || !(BACT&&RAMCS)) -> REF_CAS.
    2. BACT && RAMCS -> ACC_ROW.
    3. Otherwise stay in IDLE.
  - A RAM access requested while urgent refresh is pending waits in IDLE with RAMReady=0.
  - ACC_ROW, 1 cycle: nRAS=0, RASMux=0.
    - BACT=1 -> ACC_COL.
    - BACT=0 (aborted) -> PRE.
  - ACC_COL: RASMux=1, nCAS=0, nOE=!RW, RAMReady=1.
    - Stays until BACT=0 -> PRE.
    - RW is sampled on entry and held for the rest of the state.
  - REF_CAS, 1 cycle: nCAS=0, nRAS=1, RefBusy=1 -> REF_RAS.
  - REF_RAS: nCAS=0, nRAS=0, RefBusy=1 for exactly TRAS cycles -> PRE.
  - PRE: nRAS=nCAS=nOE=1, RAMReady=0, RASMux=0, for exactly TRP cycles -> IDLE.
    - RefBusy stays 1 through PRE if PRE was entered from refresh.
- Invariants:
  - nCAS never falls before nRAS during an access.
  - nRAS and nCAS are never both low except in ACC_COL and REF_RAS.
  - At most one refresh per RefReq-high window.
- A BACT falling edge in the cycle ACC_COL is entered still gives one RAMReady cycle, then PRE.

Test Plan:
- Reset: drive nRES=0 during REF_RAS -> next edge nRAS=nCAS=1, RefBusy=0, RefMiss=0, state IDLE.
- Idle refresh: RefReq 0->1 with BACT=0 -> REF_CAS next cycle, nRAS low exactly 3 cycles (TRAS=3), PRE 2 cycles, RefBusy high 6 cycles total; no second refresh until RefReq cycles low again.
- Read access: BACT=RAMCS=1, RW=1 ->
  - nRAS low 1 cycle before nCAS.
  - RASMux 0 then 1.
  - nOE=0 and RAMReady=1 until BACT drops.
  - Then 2 precharge cycles.
  - Write (RW=0) keeps nOE=1.
- Deferral versus urgency:
  - Pending refresh with continuous RAM accesses and RefUrg=0 -> refresh runs only in IDLE gaps between accesses.
  - With RefUrg=1 and a new RAM request in IDLE -> refresh runs first; RAMReady stays 0 until 1+TRAS+TRP cycles have elapsed.
- Miss counter:
  - Hold BACT=RAMCS=1 through a whole window with RefUrg=0 and no IDLE gap -> RefMiss increments by 1 per window.
  - After 16 missed windows -> RefMiss=15 and stays there.
- Boundary: RefReq falls on the same edge REF_RAS exits -> RefMiss unchanged, RefDone cleared the next cycle.

Source files
------------

// File: rtl/ram_refresh_seq.sv
// DRAM strobe sequencer: arbitrates CPU RAM accesses against CAS-before-RAS refresh cycles.
// Every output is a register loaded with the value of the state being entered.
module ram_refresh_seq #(
    parameter int unsigned TRP  = 2,
    parameter int unsigned TRAS = 3
) (
    input  logic       CLK,
    input  logic       nRES,
    input  logic       RefReq,
    input  logic       RefUrg,
    input  logic       BACT,
    input  logic       RAMCS,
    input  logic       RW,
    output logic       nRAS,
    output logic       nCAS,
    output logic       RASMux,
    output logic       nOE,
    output logic       RAMReady,
    output logic       RefBusy,
    output logic [3:0] RefMiss
);
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ACC_ROW = 3'd1,
        ACC_COL = 3'd2,
        REF_CAS = 3'd3,
        REF_RAS = 3'd4,
        PRE     = 3'd5
    } state_t;

    localparam logic [2:0] TRP_M1  = 3'(TRP - 1);
    localparam logic [2:0] TRAS_M1 = 3'(TRAS - 1);

    state_t     r_state, w_state_nxt;
    logic [2:0] r_cnt, w_cnt_nxt;
    logic       r_refreq, r_refdone, w_refdone_nxt;
    logic [3:0] r_refmiss, w_refmiss_nxt;
    logic       r_nras, r_ncas, r_rasmux, r_noe, r_ready, r_busy;
    logic       w_nras_nxt, w_ncas_nxt, w_rasmux_nxt, w_noe_nxt, w_ready_nxt, w_busy_nxt;
    logic       w_pending, w_acc_req, w_ref_set, w_miss;

    // State register, registered outputs and refresh bookkeeping
    always_ff @(posedge CLK) begin
        if (!nRES) begin
            r_state   <= IDLE;
            r_cnt     <= 3'd0;
            r_refreq  <= 1'b0;
            r_refdone <= 1'b0;
            r_refmiss <= 4'd0;
            r_nras    <= 1'b1;
            r_ncas    <= 1'b1;
            r_rasmux  <= 1'b0;
            r_noe     <= 1'b1;
            r_ready   <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_refreq  <= RefReq;
            r_refdone <= w_refdone_nxt;
            r_refmiss <= w_refmiss_nxt;
            r_nras    <= w_nras_nxt;
            r_ncas    <= w_ncas_nxt;
            r_rasmux  <= w_rasmux_nxt;
            r_noe     <= w_noe_nxt;
            r_ready   <= w_ready_nxt;
            r_busy    <= w_busy_nxt;
        end
    end

    // Next state and the phase counter shared by REF_RAS and PRE
    always_comb begin
        w_pending   = RefReq && !r_refdone;
        w_acc_req   = BACT && RAMCS;
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            IDLE: begin
                if (w_pending && (RefUrg || !w_acc_req)) begin
                    w_state_nxt = REF_CAS;
                end else if (w_acc_req) begin
                    w_state_nxt = ACC_ROW;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            ACC_ROW: begin
                if (BACT) begin
                    w_state_nxt = ACC_COL;
                end else begin
                    w_state_nxt = PRE;
                    w_cnt_nxt   = TRP_M1;
                end
            end
            ACC_COL: begin
                if (!BACT) begin
                    w_state_nxt = PRE;
                    w_cnt_nxt   = TRP_M1;
                end else begin
                    w_state_nxt = ACC_COL;
                end
            end
            REF_CAS: begin
                w_state_nxt = REF_RAS;
                w_cnt_nxt   = TRAS_M1;
            end
            REF_RAS: begin
                if (r_cnt == 3'd0) begin
                    w_state_nxt = PRE;
                    w_cnt_nxt   = TRP_M1;
                end else begin
                    w_cnt_nxt   = r_cnt - 3'd1;
                end
            end
            PRE: begin
                if (r_cnt == 3'd0) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_cnt_nxt   = r_cnt - 3'd1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = 3'd0;
            end
        endcase
    end

    // Output values of the state being entered; RW is latched into nOE on ACC_COL entry only
    always_comb begin
        w_nras_nxt   = 1'b1;
        w_ncas_nxt   = 1'b1;
        w_rasmux_nxt = 1'b0;
        w_noe_nxt    = 1'b1;
        w_ready_nxt  = 1'b0;
        w_busy_nxt   = 1'b0;
        case (w_state_nxt)
            ACC_ROW: begin
                w_nras_nxt = 1'b0;
            end
            ACC_COL: begin
                w_nras_nxt   = 1'b0;
                w_ncas_nxt   = 1'b0;
                w_rasmux_nxt = 1'b1;
                w_ready_nxt  = 1'b1;
                w_noe_nxt    = (r_state == ACC_COL) ? r_noe : !RW;
            end
            REF_CAS: begin
                w_ncas_nxt = 1'b0;
                w_busy_nxt = 1'b1;
            end
            REF_RAS: begin
                w_nras_nxt = 1'b0;
                w_ncas_nxt = 1'b0;
                w_busy_nxt = 1'b1;
            end
            PRE: begin
                w_busy_nxt = (r_state == REF_RAS) || ((r_state == PRE) && r_busy);
            end
            default: begin
                w_busy_nxt = 1'b0;
            end
        endcase
    end

    // A refresh completing on the same edge the window closes is not a miss
    always_comb begin
        w_ref_set = (r_state == REF_RAS) && (w_state_nxt == PRE);
        w_miss    = r_refreq && !RefReq && !r_refdone && !w_ref_set;
        if (w_ref_set) begin
            w_refdone_nxt = 1'b1;
        end else if (!RefReq) begin
            w_refdone_nxt = 1'b0;
        end else begin
            w_refdone_nxt = r_refdone;
        end
        if (w_miss && (r_refmiss != 4'd15)) begin
            w_refmiss_nxt = r_refmiss + 4'd1;
        end else begin
            w_refmiss_nxt = r_refmiss;
        end
    end

    assign nRAS     = r_nras;
    assign nCAS     = r_ncas;
    assign RASMux   = r_rasmux;
    assign nOE      = r_noe;
    assign RAMReady = r_ready;
    assign RefBusy  = r_busy;
    assign RefMiss  = r_refmiss;
endmodule
